// File: rtl/tis_stream_sink.sv
// tis_stream_sink: reader-side endpoint of the 15-bit inter-node link.
// Completes the four-phase word handshake with a writer node, buffers the
// received signed 11-bit words in a first-word-fall-through FIFO and offers
// them on a valid/ready output stream.
//
// Handshake semantics (both sides):
//   link side  : the writer raises link_in[11] with data on link_in[10:0] and
//                holds both until it sees ack (link_out[12]). It then drops
//                valid, and the sink drops ack. Each valid pulse yields
//                exactly one word, however long valid is held.
//   host side  : out_data/out_valid present the FIFO head. The head is
//                consumed on a rising edge where out_valid && out_ready.
//                out_ready while empty has no effect.
module tis_stream_sink #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [14:0]       link_in,
    output logic [14:0]       link_out,
    output logic [10:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fill,
    output logic [15:0]       word_count,
    output logic              proto_err,
    output logic              state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_FILL = (ADDR_W+1)'(DEPTH);

    state_t              state;
    state_t              next_state;
    logic                push;
    logic                pop;
    logic                full;
    logic                stall;
    logic                stall_q;
    logic [10:0]         data_q;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [10:0]         mem [DEPTH];

    logic                link_valid;
    logic [10:0]         link_data;
    logic [1:0]          link_rsv;
    logic                unused_writer_ack;

    assign link_valid        = link_in[11];
    assign link_data         = link_in[10:0];
    assign link_rsv          = link_in[14:13];
    // The writer's own ack bit only matters on the reverse direction.
    assign unused_writer_ack = link_in[12];

    // Full test deliberately uses the registered occupancy, so a pop in the
    // same cycle does not free a slot for the incoming word until next cycle.
    assign full      = (fill == FULL_FILL);
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : 11'h000;

    // ack is a direct function of the state register, so it is glitch-free
    // and drops the instant reset is asserted.
    assign link_out  = {2'b00, (state == ACK), 12'h000};
    assign state_dbg = state;

    // Link state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Link next-state and push decision.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (link_valid && !full) begin
                    push       = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                if (!link_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= link_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Count of accepted words, free-running with natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= 16'h0000;
        end else if (push) begin
            word_count <= word_count + 16'h0001;
        end
    end

    // A writer stalled on a full FIFO must keep its data stable until ack.
    assign stall = (state == IDLE) && link_valid && full;

    // Sticky protocol error: reserved bits set with valid, or data changing
    // between two consecutive stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            stall_q   <= 1'b0;
            data_q    <= 11'h000;
        end else begin
            stall_q <= stall;
            data_q  <= link_data;
            if ((link_valid && (link_rsv != 2'b00)) ||
                (stall && stall_q && (link_data != data_q))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tis_stream_sink.sv
// Bench for tis_stream_sink: directed vector table, hand-written multi-cycle
// sequences (async reset mid-handshake, stalled-data error), then randomized
// traffic checked against a queue-based reference model.
module tb_tis_stream_sink;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic [14:0]       link_in;
    logic [14:0]       link_out;
    logic [10:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   fill;
    logic [15:0]       word_count;
    logic              proto_err;
    logic              state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    tis_stream_sink #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_in    (link_in),
        .link_out   (link_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill       (fill),
        .word_count (word_count),
        .proto_err  (proto_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ack, input logic ov,
                           input logic [10:0] od, input logic [ADDR_W:0] fl,
                           input logic [15:0] cnt, input logic err);
        chk({tag, ".ack"},  {15'd0, link_out[12]}, {15'd0, ack});
        chk({tag, ".rest"}, {1'b0, link_out & 15'h6FFF}, 16'h0000);
        chk({tag, ".ovld"}, {15'd0, out_valid}, {15'd0, ov});
        chk({tag, ".data"}, {5'd0, out_data}, {5'd0, od});
        chk({tag, ".fill"}, {{(15-ADDR_W){1'b0}}, fill}, {{(15-ADDR_W){1'b0}}, fl});
        chk({tag, ".cnt"},  word_count, cnt);
        chk({tag, ".err"},  {15'd0, proto_err}, {15'd0, err});
    endtask

    // ---------------- reference model ----------------
    logic [10:0] m_q[$];
    bit          m_acked;
    logic [15:0] m_cnt;
    bit          m_err;
    bit          m_stall_q;
    logic [10:0] m_data_q;

    task automatic model_reset();
        m_q.delete();
        m_acked   = 0;
        m_cnt     = 16'h0;
        m_err     = 0;
        m_stall_q = 0;
        m_data_q  = 11'h0;
    endtask

    // One clock edge of the endpoint as seen from outside: a writer pulse is
    // taken once when there is room, the host pops the head when ready.
    task automatic model_step(input logic [14:0] li, input logic rdy);
        bit v;
        bit do_pop;
        bit do_push;
        bit stall;
        v       = li[11];
        do_pop  = (m_q.size() != 0) && rdy;
        do_push = v && !m_acked && (m_q.size() < DEPTH);
        stall   = v && !m_acked && (m_q.size() == DEPTH);
        if (v && (li[14:13] != 2'b00)) m_err = 1;
        if (stall && m_stall_q && (li[10:0] != m_data_q)) m_err = 1;
        m_stall_q = stall;
        m_data_q  = li[10:0];
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back(li[10:0]);
            m_cnt = m_cnt + 16'h1;
        end
        m_acked = m_acked ? v : do_push;
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_acked, m_q.size() != 0,
                (m_q.size() != 0) ? m_q[0] : 11'h000,
                (ADDR_W+1)'(m_q.size()), m_cnt, m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic vld, input logic [10:0] d, input logic [1:0] rsv, input logic rdy);
        link_in   = {rsv, 1'b0, vld, d};
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 11'h0, 2'b00, 1'b0);
        tick();
        chk_all("reset", 1'b0, 1'b0, 11'h0, '0, 16'h0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            vld;
        logic [10:0]     d;
        logic [1:0]      rsv;
        logic            rdy;
        logic            ack;
        logic            ov;
        logic [10:0]     od;
        logic [ADDR_W:0] fl;
        logic [15:0]     cnt;
        logic            err;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic vld, input logic [10:0] d, input logic [1:0] rsv, input logic rdy,
                       input logic ack, input logic ov, input logic [10:0] od,
                       input logic [ADDR_W:0] fl, input logic [15:0] cnt, input logic err);
        vecs[nv] = '{vld, d, rsv, rdy, ack, ov, od, fl, cnt, err};
        nv++;
    endtask

    // ---------------- random writer state ----------------
    logic        w_vld;
    logic [10:0] w_data;
    int          rdy_pct;

    initial begin
        rst_n     = 1'b0;
        link_in   = 15'h0;
        out_ready = 1'b0;
        model_reset();

        // Single word, then drop valid and drain.
        add(1, 11'd5,   0, 0,   1, 1, 11'd5,   1, 1, 0);
        add(1, 11'd5,   0, 0,   1, 1, 11'd5,   1, 1, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd5,   1, 1, 0);
        add(0, 11'd0,   0, 1,   0, 0, 11'd0,   0, 1, 0);
        // Negative value -999 stored bit-exact.
        add(1, 11'h419, 0, 0,   1, 1, 11'h419, 1, 2, 0);
        add(0, 11'd0,   0, 1,   0, 0, 11'd0,   0, 2, 0);
        // Fill to full with out_ready low.
        add(1, 11'd1,   0, 0,   1, 1, 11'd1,   1, 3, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd1,   1, 3, 0);
        add(1, 11'd2,   0, 0,   1, 1, 11'd1,   2, 4, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd1,   2, 4, 0);
        add(1, 11'd3,   0, 0,   1, 1, 11'd1,   3, 5, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd1,   3, 5, 0);
        add(1, 11'd4,   0, 0,   1, 1, 11'd1,   4, 6, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd1,   4, 6, 0);
        // Fifth word stalls; a pop does not admit it in the same cycle.
        add(1, 11'd5,   0, 0,   0, 1, 11'd1,   4, 6, 0);
        add(1, 11'd5,   0, 0,   0, 1, 11'd1,   4, 6, 0);
        add(1, 11'd5,   0, 1,   0, 1, 11'd2,   3, 6, 0);
        add(1, 11'd5,   0, 0,   1, 1, 11'd2,   4, 7, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd2,   4, 7, 0);
        // Drain to fill=2, then simultaneous push/pop.
        add(0, 11'd0,   0, 1,   0, 1, 11'd3,   3, 7, 0);
        add(0, 11'd0,   0, 1,   0, 1, 11'd4,   2, 7, 0);
        add(1, 11'd6,   0, 1,   1, 1, 11'd5,   2, 8, 0);
        add(0, 11'd0,   0, 1,   0, 1, 11'd6,   1, 8, 0);
        add(0, 11'd0,   0, 1,   0, 0, 11'd0,   0, 8, 0);
        // Valid held for ten cycles: exactly one push.
        for (int i = 0; i < 10; i++) add(1, 11'd7, 0, 0, 1, 1, 11'd7, 1, 9, 0);
        add(0, 11'd0,   0, 0,   0, 1, 11'd7,   1, 9, 0);
        add(0, 11'd0,   0, 1,   0, 0, 11'd0,   0, 9, 0);
        // Reserved bit with valid: sticky error, FSM carries on.
        add(1, 11'd8,   1, 0,   1, 1, 11'd8,   1, 10, 1);
        add(0, 11'd0,   0, 0,   0, 1, 11'd8,   1, 10, 1);
        add(1, 11'd9,   0, 0,   1, 1, 11'd8,   2, 11, 1);
        add(0, 11'd0,   0, 0,   0, 1, 11'd8,   2, 11, 1);

        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 11'h0, '0, 16'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].vld, vecs[i].d, vecs[i].rsv, vecs[i].rdy);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].ov, vecs[i].od,
                    vecs[i].fl, vecs[i].cnt, vecs[i].err);
        end

        // Async reset while in ACK with fill=3: ack drops at once, held word re-accepted.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 11'(100 * (i + 1)), 2'b00, 1'b0);
            tick();
            drive(1'b0, 11'h0, 2'b00, 1'b0);
            tick();
        end
        drive(1'b1, 11'd300, 2'b00, 1'b0);
        tick();
        chk_all("pre_rst", 1'b1, 1'b1, 11'd100, 3, 16'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("in_rst", 1'b0, 1'b0, 11'h0, 0, 16'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 1'b1, 1'b1, 11'd300, 1, 16'd1, 1'b0);

        // Writer changes data while stalled on a full FIFO.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 11'(i + 20), 2'b00, 1'b0);
            tick();
            drive(1'b0, 11'h0, 2'b00, 1'b0);
            tick();
        end
        drive(1'b1, 11'd50, 2'b00, 1'b0);
        tick();
        tick();
        chk_all("stall_ok", 1'b0, 1'b1, 11'd20, 4, 16'd4, 1'b0);
        drive(1'b1, 11'd51, 2'b00, 1'b0);
        tick();
        chk_all("stall_chg", 1'b0, 1'b1, 11'd20, 4, 16'd4, 1'b1);
        drive(1'b0, 11'h0, 2'b00, 1'b0);
        tick();
        chk_all("err_stick", 1'b0, 1'b1, 11'd20, 4, 16'd4, 1'b1);
        do_reset();

        // Randomized legal four-phase writer with varying host backpressure.
        w_vld   = 1'b0;
        w_data  = 11'h0;
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rdy_pct = $urandom_range(5, 95);
            if (w_vld && m_acked && ($urandom_range(0, 1) == 1)) begin
                w_vld = 1'b0;
            end else if (!w_vld && !m_acked && ($urandom_range(0, 2) == 0)) begin
                w_vld  = 1'b1;
                w_data = 11'($urandom);
            end
            drive(w_vld, w_data, 2'b00, ($urandom_range(0, 99) < rdy_pct));
            model_step(link_in, out_ready);
            tick();
            chk_model("rnd");
        end

        // Unconstrained link traffic, including reserved bits and unstable data.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 1) == 1, 11'($urandom),
                  ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 2) == 0);
            model_step(link_in, out_ready);
            tick();
            chk_model("chaos");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
